// File: rtl/usb2_crc_engine.sv
// USB 2.0 CRC5/CRC16 engine: one byte folded per clock, in_ready low while a beat's lanes drain; result 2 cycles after token accept, 1 after final fold.
// Optional receive residual check (crc_ok) is compiled in with USB2_CRC_CHECK_EN; otherwise crc_ok is tied low.
module usb2_crc_engine #(
   parameter int DATA_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    tok_valid,
   input  logic [10:0]             tok_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [DATA_BYTES-1:0]   in_be,
   input  logic                    in_last,
   output logic                    crc_valid,
   output logic                    crc_mode,
   output logic [15:0]             crc_out,
   output logic                    crc_ok
);

   localparam int LW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   typedef enum logic [1:0] {IDLE, TOKEN, DATA, DONE} state_t;

   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (b[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
      if (b ^ c[4]) return {c[3:0], 1'b0} ^ 5'h05;
      else          return {c[3:0], 1'b0};
   endfunction

   function automatic logic [4:0] crc5_tok(input logic [10:0] t);
      logic [4:0] r;
      r = 5'h1F;
      for (int i = 0; i < 11; i++) r = crc5_step(r, t[i]);
      return r;
   endfunction

   // Complement and reverse so that bit 0 of the result is the first bit on the wire.
   function automatic logic [15:0] tx16(input logic [15:0] c);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
      return r;
   endfunction

   function automatic logic [4:0] tx5(input logic [4:0] c);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic [15:0]             crc_q, crc_d;
   logic [10:0]             tok_q, tok_d;
   logic [8*DATA_BYTES-1:0] buf_q, buf_d;
   logic [DATA_BYTES-1:0]   be_q, be_d;
   logic                    last_q, last_d;
   logic [LW-1:0]           lane_q, lane_d;
   logic                    full_q, full_d;
   logic                    rdy_q;
   logic [15:0]             out_q, out_d;
   logic                    mode_q, mode_d;
   logic                    take_beat;
   logic [7:0]              cur_byte;
   logic [DATA_BYTES:0]     be_rest;
   logic                    final_lane;
   logic [15:0]             crc_fold;
   logic [4:0]              c5;

`ifdef USB2_CRC_CHECK_EN
   logic [4:0]              chk_q, chk_d;
   logic                    ok_q, ok_d;
   logic [4:0]              c5_res;

   always_comb begin
      c5_res = c5;
      for (int i = 0; i < 5; i++) c5_res = crc5_step(c5_res, chk_q[i]);
   end
`endif

   assign cur_byte   = 8'(buf_q >> {lane_q, 3'b000});
   assign be_rest    = {1'b0, be_q} >> lane_q;
   assign final_lane = ~be_rest[1];
   assign crc_fold   = crc16_byte(crc_q, cur_byte);
   assign c5         = crc5_tok(tok_q);

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      tok_d     = tok_q;
      buf_d     = buf_q;
      be_d      = be_q;
      last_d    = last_q;
      lane_d    = lane_q;
      full_d    = full_q;
      out_d     = out_q;
      mode_d    = mode_q;
`ifdef USB2_CRC_CHECK_EN
      chk_d     = chk_q;
      ok_d      = ok_q;
`endif
      in_ready  = 1'b0;
      crc_valid = 1'b0;
      take_beat = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = rdy_q;
            if (rdy_q && tok_valid) begin
               state_d = TOKEN;
               tok_d   = tok_data;
`ifdef USB2_CRC_CHECK_EN
               chk_d   = in_data[4:0];
`endif
            end else if (rdy_q && in_valid) begin
               take_beat = 1'b1;
               crc_d     = 16'hFFFF;
               if (in_be == '0) begin
                  state_d = DONE;
                  out_d   = 16'h0000;
                  mode_d  = 1'b1;
`ifdef USB2_CRC_CHECK_EN
                  ok_d    = 1'b0;
`endif
               end else begin
                  state_d = DATA;
               end
            end
         end
         TOKEN: begin
            state_d = DONE;
            out_d   = {11'h000, tx5(c5)};
            mode_d  = 1'b0;
`ifdef USB2_CRC_CHECK_EN
            ok_d    = (c5_res == 5'b01100);
`endif
         end
         DATA: begin
            if (!full_q) begin
               // Mid-packet gap: waiting for the next beat with the running CRC kept.
               in_ready  = 1'b1;
               take_beat = in_valid;
            end else begin
               crc_d = crc_fold;
               if (!final_lane) begin
                  lane_d = lane_q + 1'b1;
               end else if (last_q) begin
                  state_d = DONE;
                  full_d  = 1'b0;
                  out_d   = tx16(crc_fold);
                  mode_d  = 1'b1;
`ifdef USB2_CRC_CHECK_EN
                  ok_d    = (crc_fold == 16'h800D);
`endif
               end else begin
                  in_ready  = 1'b1;
                  take_beat = in_valid;
                  full_d    = 1'b0;
               end
            end
         end
         DONE: begin
            crc_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (take_beat) begin
         buf_d  = in_data;
         be_d   = in_be;
         last_d = in_last;
         lane_d = '0;
         full_d = |in_be;
      end

      // Abort: drop the packet but keep the last reported result.
      if (clear) begin
         state_d = IDLE;
         crc_d   = 16'hFFFF;
         buf_d   = '0;
         be_d    = '0;
         last_d  = 1'b0;
         lane_d  = '0;
         full_d  = 1'b0;
         out_d   = out_q;
         mode_d  = mode_q;
`ifdef USB2_CRC_CHECK_EN
         ok_d    = ok_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         crc_q   <= 16'hFFFF;
         tok_q   <= '0;
         buf_q   <= '0;
         be_q    <= '0;
         last_q  <= 1'b0;
         lane_q  <= '0;
         full_q  <= 1'b0;
         rdy_q   <= 1'b0;
         out_q   <= 16'h0000;
         mode_q  <= 1'b0;
`ifdef USB2_CRC_CHECK_EN
         chk_q   <= '0;
         ok_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         tok_q   <= tok_d;
         buf_q   <= buf_d;
         be_q    <= be_d;
         last_q  <= last_d;
         lane_q  <= lane_d;
         full_q  <= full_d;
         rdy_q   <= 1'b1;
         out_q   <= out_d;
         mode_q  <= mode_d;
`ifdef USB2_CRC_CHECK_EN
         chk_q   <= chk_d;
         ok_q    <= ok_d;
`endif
      end
   end

   assign crc_out  = out_q;
   assign crc_mode = mode_q;
`ifdef USB2_CRC_CHECK_EN
   assign crc_ok   = ok_q;
`else
   assign crc_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_usb2_crc_engine.sv
// Bench for usb2_crc_engine: table-driven token/data vectors checked through a scoreboard, plus clear, arbitration and reset sequences.
module tb_usb2_crc_engine;

   localparam int DB = 4;
`ifdef USB2_CRC_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clear = 1'b0;
   logic          tok_valid = 1'b0;
   logic [10:0]   tok_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [8*DB-1:0] in_data = '0;
   logic [DB-1:0] in_be = '0;
   logic          in_last = 1'b0;
   logic          crc_valid;
   logic          crc_mode;
   logic [15:0]   crc_out;
   logic          crc_ok;

   always #5 clk = ~clk;

   usb2_crc_engine #(.DATA_BYTES(DB)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .tok_valid(tok_valid), .tok_data(tok_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_be(in_be), .in_last(in_last),
      .crc_valid(crc_valid), .crc_mode(crc_mode), .crc_out(crc_out), .crc_ok(crc_ok)
   );

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        mode;
      logic [15:0] crc;
      logic        ok;
   } exp_t;

   exp_t sbq[$];

   typedef struct {
      logic [7:0]  dat [12];
      int          len;
      int          bsz [4];
      int          nb;
      logic [15:0] exp_crc;
      logic        exp_ok;
   } dvec_t;

   typedef struct {
      logic [10:0] tok;
      logic [4:0]  chk;
      logic [15:0] exp_crc;
      logic        exp_ok;
   } tvec_t;

   localparam int NDV = 8;
   localparam int NTV = 3;
   dvec_t dv [NDV];
   tvec_t tv [NTV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference models use the reflected (shift-right) CRC form.
   function automatic logic [15:0] ref16(input logic [7:0] d [12], input int n);
      logic [15:0] r;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 8; j++)
            if (r[0] ^ d[i][j]) r = (r >> 1) ^ 16'hA001;
            else                r = r >> 1;
      return r;
   endfunction

   function automatic logic [4:0] ref5(input logic [10:0] t, input logic [4:0] c, input int nchk);
      logic [4:0] r;
      r = 5'h1F;
      for (int i = 0; i < 11; i++)
         if (r[0] ^ t[i]) r = (r >> 1) ^ 5'h14;
         else             r = r >> 1;
      for (int i = 0; i < nchk; i++)
         if (r[0] ^ c[i]) r = (r >> 1) ^ 5'h14;
         else             r = r >> 1;
      return r;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n && crc_valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_crc_valid", crc_valid, 0);
         end else begin
            e = sbq.pop_front();
            chk("crc_out", crc_out, e.crc);
            chk("crc_mode", crc_mode, e.mode);
            chk("crc_ok", crc_ok, e.ok);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] be, input logic last,
                            input logic push, input exp_t e, output int waits);
      in_valid = 1'b1;
      in_data  = d;
      in_be    = be;
      in_last  = last;
      waits    = 0;
      while (!in_ready && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      chk("beat_accept", in_ready, 1);
      @(posedge clk);
      if (push) sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_vec(input int idx, input logic push, output int wl);
      int   p;
      exp_t e;
      p = 0;
      e.mode = 1'b1;
      e.crc  = dv[idx].exp_crc;
      e.ok   = dv[idx].exp_ok;
      for (int b = 0; b < dv[idx].nb; b++) begin
         logic [31:0] d;
         logic [3:0]  be;
         int          w;
         d  = '0;
         be = '0;
         for (int k = 0; k < dv[idx].bsz[b]; k++) begin
            d[8*k +: 8] = dv[idx].dat[p];
            be[k]       = 1'b1;
            p++;
         end
         send_beat(d, be, b == dv[idx].nb - 1, push && (b == dv[idx].nb - 1), e, w);
         wl = w;
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!crc_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic set_dv(input int i, input logic [7:0] d [12], input int len,
                         input int b0, input int b1, input int b2, input int b3, input int nb,
                         input logic [15:0] c, input logic use_model);
      dv[i].dat = d;
      dv[i].len = len;
      dv[i].bsz = '{b0, b1, b2, b3};
      dv[i].nb  = nb;
      dv[i].exp_crc = use_model ? ~ref16(d, len) : c;
      dv[i].exp_ok  = CHECK && (ref16(d, len) == 16'hB001);
   endtask

   initial begin : main
      logic [7:0] base [12];
      logic [7:0] tmp  [12];
      int   wl;
      int   lat;
      exp_t e;

      base = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94, 8'h00, 8'h00};
      set_dv(0, base, 8, 4, 4, 0, 0, 2, 16'h94DD, 1'b0);
      set_dv(1, base, 8, 1, 3, 4, 0, 3, 16'h94DD, 1'b0);
      set_dv(2, base, 8, 2, 2, 2, 2, 4, 16'h94DD, 1'b0);
      set_dv(3, base, 0, 0, 0, 0, 0, 1, 16'h0000, 1'b0);
      tmp = base;
      tmp[0] = 8'hA5;
      set_dv(4, tmp, 1, 1, 0, 0, 0, 1, 16'h0000, 1'b1);
      for (int i = 0; i < 12; i++) tmp[i] = 8'($urandom_range(0, 255));
      set_dv(5, tmp, 7, 3, 4, 0, 0, 2, 16'h0000, 1'b1);
      set_dv(6, base, 10, 4, 4, 2, 0, 3, 16'h0000, 1'b1);
      tmp = base;
      tmp[2] = 8'h01;
      set_dv(7, tmp, 10, 4, 4, 2, 0, 3, 16'h0000, 1'b1);

      tv[0] = '{11'h000, 5'h00, 16'h0002, 1'b0};
      tv[1] = '{11'h415, 5'h00, {11'h000, ~ref5(11'h415, 5'h00, 0)}, 1'b0};
      tv[2] = '{11'h3A7, ~ref5(11'h3A7, 5'h00, 0), {11'h000, ~ref5(11'h3A7, 5'h00, 0)}, 1'b0};
      for (int i = 0; i < NTV; i++)
         tv[i].exp_ok = CHECK && (ref5(tv[i].tok, tv[i].chk, 5) == 5'h06);

      // Power-up reset
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_crc_valid", crc_valid, 0);
      chk("rst_crc_mode", crc_mode, 0);
      chk("rst_crc_out", crc_out, 16'h0000);
      chk("rst_crc_ok", crc_ok, 0);
      reset_n = 1'b1;
      #1 chk("ready_before_first_edge", in_ready, 0);
      @(negedge clk);
      chk("ready_after_first_edge", in_ready, 1);

      // Tokens
      for (int i = 0; i < NTV; i++) begin
         wait_idle();
         tok_valid = 1'b1;
         tok_data  = tv[i].tok;
         in_data   = {27'h0, tv[i].chk};
         @(posedge clk);
         e = '{1'b0, tv[i].exp_crc, tv[i].exp_ok};
         sbq.push_back(e);
         @(negedge clk);
         tok_valid = 1'b0;
         in_data   = '0;
         wait_valid(lat);
         chk("token_latency", lat, 2);
      end

      // Data packets
      for (int i = 0; i < NDV; i++) begin
         wait_idle();
         send_vec(i, 1'b1, wl);
         if (dv[i].nb > 1) chk("last_beat_ready_wait", wl, dv[i].bsz[dv[i].nb-2] - 1);
         wait_valid(lat);
         chk("data_latency", lat, dv[i].bsz[dv[i].nb-1] + 1);
      end

      // Clear during the 5th fold, then a clean packet
      wait_idle();
      e = '0;
      send_beat({8'h01, 8'h00, 8'h06, 8'h80}, 4'hF, 1'b0, 1'b0, e, wl);
      send_beat({8'h00, 8'h40, 8'h00, 8'h00}, 4'hF, 1'b1, 1'b0, e, wl);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("idle_after_clear", in_ready, 1);
      repeat (8) @(negedge clk);
      send_vec(0, 1'b1, wl);
      wait_valid(lat);
      chk("post_clear_latency", lat, 5);

      // Token and data beat together in IDLE: token wins, beat stalls
      wait_idle();
      @(negedge clk);
      tok_valid = 1'b1;
      tok_data  = tv[0].tok;
      in_data   = {8'h01, 8'h00, 8'h06, 8'h80};
      in_be     = 4'hF;
      in_last   = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      e = '{1'b0, tv[0].exp_crc, tv[0].exp_ok};
      sbq.push_back(e);
      @(negedge clk);
      tok_valid = 1'b0;
      e.mode = 1'b1;
      e.crc  = ~ref16(base, 4);
      e.ok   = CHECK && (ref16(base, 4) == 16'hB001);
      send_beat({8'h01, 8'h00, 8'h06, 8'h80}, 4'hF, 1'b1, 1'b1, e, wl);
      chk("beat_stall_behind_token", wl, 2);
      wait_valid(lat);
      chk("arb_data_latency", lat, 5);

      // Reset asserted mid-DATA with in_valid high
      wait_idle();
      e = '0;
      send_beat({8'h01, 8'h00, 8'h06, 8'h80}, 4'hF, 1'b0, 1'b0, e, wl);
      in_valid = 1'b1;
      reset_n  = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_crc_valid", crc_valid, 0);
      chk("mid_rst_crc_mode", crc_mode, 0);
      chk("mid_rst_crc_out", crc_out, 16'h0000);
      chk("mid_rst_crc_ok", crc_ok, 0);
      @(negedge clk);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      #1 chk("mid_rst_ready_before_edge", in_ready, 0);
      @(negedge clk);
      chk("mid_rst_ready_after_edge", in_ready, 1);
      send_vec(1, 1'b1, wl);
      wait_valid(lat);
      chk("post_reset_latency", lat, 5);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
